// File: rtl/elevator_scheduler_if.sv
// Handshake bundle between the elevator scheduler and its button panel / floor machine.
// The door_hold signal exists only when SCHED_DOOR_HOLD_EN is defined.
interface elevator_scheduler_if;
    logic [3:0] call_btn;
    logic [1:0] current_floor;
`ifdef SCHED_DOOR_HOLD_EN
    logic       door_hold;
`endif
    logic       stop_go;
    logic       up_down;
    logic       door_open;
    logic [3:0] pending;
    logic       busy;

`ifdef SCHED_DOOR_HOLD_EN
    modport master (
        output call_btn, current_floor, door_hold,
        input  stop_go, up_down, door_open, pending, busy
    );
    modport slave (
        input  call_btn, current_floor, door_hold,
        output stop_go, up_down, door_open, pending, busy
    );
`else
    modport master (
        output call_btn, current_floor,
        input  stop_go, up_down, door_open, pending, busy
    );
    modport slave (
        input  call_btn, current_floor,
        output stop_go, up_down, door_open, pending, busy
    );
`endif
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN request scheduler driving a 4-floor car-position machine one floor step at a time.
// Optional door-hold extension of the dwell is enabled by defining SCHED_DOOR_HOLD_EN.
module elevator_scheduler #(
    parameter int DOOR_CYCLES = 8
) (
    input logic                 CLK,
    input logic                 RST,
    elevator_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STEP, CHECK, DOOR} state_t;

    localparam logic [7:0] DWELL_LOAD = 8'(DOOR_CYCLES - 1);

    state_t     state;
    logic       dir;
    logic [7:0] cnt;
    logic [3:0] pend;

    logic [3:0] here;
    logic [3:0] above_mask;
    logic [3:0] below_mask;
    logic [3:0] btn_eff;
    logic [3:0] clr;
    logic       any_above;
    logic       any_below;
    logic       ahead;
    logic       at_here;
    logic       enter_door;
    logic       hold;

    always_comb begin
        here       = 4'b0001 << bus.current_floor;
        above_mask = 4'b0000;
        below_mask = 4'b0000;
        case (bus.current_floor)
            2'd0: begin above_mask = 4'b1110; below_mask = 4'b0000; end
            2'd1: begin above_mask = 4'b1100; below_mask = 4'b0001; end
            2'd2: begin above_mask = 4'b1000; below_mask = 4'b0011; end
            2'd3: begin above_mask = 4'b0000; below_mask = 4'b0111; end
            default: begin above_mask = 4'b0000; below_mask = 4'b0000; end
        endcase
    end

    assign any_above  = |(pend & above_mask);
    assign any_below  = |(pend & below_mask);
    assign ahead      = dir ? any_above : any_below;
    assign at_here    = |(pend & here);
    assign enter_door = at_here && ((state == IDLE) || (state == CHECK));
    // A call for the floor the door is already open at is served by this dwell.
    assign btn_eff    = bus.call_btn & ~((state == DOOR) ? here : 4'b0000);
    assign clr        = enter_door ? here : 4'b0000;

`ifdef SCHED_DOOR_HOLD_EN
    assign hold = bus.door_hold;
`else
    assign hold = 1'b0;
`endif

    assign bus.pending = pend;
    assign bus.up_down = dir;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            dir           <= 1'b1;
            cnt           <= 8'd0;
            pend          <= 4'b0000;
            bus.stop_go   <= 1'b1;
            bus.door_open <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            pend <= (pend | btn_eff) & ~clr;
            case (state)
                IDLE: begin
                    if (at_here) begin
                        state         <= DOOR;
                        cnt           <= DWELL_LOAD;
                        bus.door_open <= 1'b1;
                        bus.busy      <= 1'b1;
                    end else if (|pend) begin
                        // SCAN: keep heading while work lies ahead, otherwise reverse.
                        dir         <= dir ? any_above : ~any_below;
                        state       <= STEP;
                        bus.stop_go <= 1'b0;
                        bus.busy    <= 1'b1;
                    end
                end
                STEP: begin
                    state       <= CHECK;
                    bus.stop_go <= 1'b1;
                end
                CHECK: begin
                    if (at_here) begin
                        state         <= DOOR;
                        cnt           <= DWELL_LOAD;
                        bus.door_open <= 1'b1;
                    end else if (ahead) begin
                        state       <= STEP;
                        bus.stop_go <= 1'b0;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                DOOR: begin
                    if (hold) begin
                        cnt <= DWELL_LOAD;
                    end else if (cnt == 8'd0) begin
                        state         <= IDLE;
                        bus.door_open <= 1'b0;
                        bus.busy      <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.stop_go   <= 1'b1;
                    bus.door_open <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_scheduler.sv
// Closed-loop bench: a floor-machine plant plus a behavioural SCAN model checked every cycle.
module tb_elevator_scheduler;
`ifdef SCHED_DOOR_HOLD_EN
    localparam int DC = 4;
`else
    localparam int DC = 8;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;

    elevator_scheduler_if bus();

    elevator_scheduler #(.DOOR_CYCLES(DC)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial forever #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    bit [3:0] btn;
    bit       hold_v;
    bit       rst_v;
    bit       armed;

    // behavioural model: pending set, heading, remaining door cycles, moving / just-arrived flags
    bit [3:0] m_pend;
    bit       m_dir;
    int       m_dwell;
    bit       m_step;
    bit       m_arr;
    int       plant;

    int cyc, n_steps, n_up, n_down, n_door, rise_cyc;
    int df[$];
    bit prev_door;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit req_above(input bit [3:0] p, input int f);
        for (int i = f + 1; i < 4; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit req_below(input bit [3:0] p, input int f);
        for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        bit [3:0] bm, np;
        int nd, pf;
        bit ns, na, ndir, enter;
        int f;
        f = plant;
        bm = btn;
        if (m_dwell > 0) bm[f] = 1'b0;
        np = m_pend | bm;
        nd = m_dwell; ns = 1'b0; na = 1'b0; ndir = m_dir; enter = 1'b0;
        if (m_dwell > 0) begin
            nd = hold_v ? DC : m_dwell - 1;
        end else if (m_step) begin
            na = 1'b1;
        end else if (m_pend != 4'b0000) begin
            if (m_pend[f]) enter = 1'b1;
            else if (m_arr) ns = (m_dir ? req_above(m_pend, f) : req_below(m_pend, f));
            else begin
                ndir = m_dir ? req_above(m_pend, f) : !req_below(m_pend, f);
                ns = 1'b1;
            end
        end
        if (enter) begin
            nd = DC;
            np[f] = 1'b0;
        end

        if (armed && !rst_v)
            chk("boundary", (bus.stop_go === 1'b0 &&
                ((bus.up_down === 1'b1 && plant == 3) || (bus.up_down === 1'b0 && plant == 0))) ? 1 : 0, 0);
        pf = plant;
        if (bus.stop_go === 1'b0) pf = (bus.up_down === 1'b1) ? plant + 1 : plant - 1;
        if (pf > 3) pf = 3;
        if (pf < 0) pf = 0;
        if (rst_v) pf = 0;

        bus.call_btn = btn;
        RST = rst_v;
`ifdef SCHED_DOOR_HOLD_EN
        bus.door_hold = hold_v;
`endif
        @(posedge CLK);
        #1;
        if (rst_v) begin
            m_pend = 4'b0000; m_dir = 1'b1; m_dwell = 0; m_step = 1'b0; m_arr = 1'b0;
            armed = 1'b1;
        end else begin
            m_pend = np; m_dir = ndir; m_dwell = nd; m_step = ns; m_arr = na;
        end
        plant = pf;
        bus.current_floor = 2'(plant);
        cyc++;

        if (armed) begin
            chk("stop_go",   int'(bus.stop_go),   m_step ? 0 : 1);
            chk("up_down",   int'(bus.up_down),   int'(m_dir));
            chk("door_open", int'(bus.door_open), (m_dwell > 0) ? 1 : 0);
            chk("pending",   int'(bus.pending),   int'(m_pend));
            chk("busy",      int'(bus.busy),      (m_step || m_arr || m_dwell > 0) ? 1 : 0);
            chk("step_in_door", (bus.stop_go === 1'b0 && bus.door_open === 1'b1) ? 1 : 0, 0);
        end

        if (bus.stop_go === 1'b0) begin
            n_steps++;
            if (bus.up_down === 1'b1) n_up++; else n_down++;
        end
        if (bus.door_open === 1'b1) begin
            n_door++;
            if (!prev_door) begin
                df.push_back(plant);
                rise_cyc = cyc;
            end
        end
        prev_door = (bus.door_open === 1'b1);
    endtask

    task automatic clear_stats();
        n_steps = 0; n_up = 0; n_down = 0; n_door = 0; rise_cyc = -1;
        df.delete();
    endtask

    task automatic do_reset();
        btn = 4'b0000; hold_v = 1'b0; rst_v = 1'b1;
        tick(); tick();
        rst_v = 1'b0;
    endtask

    task automatic pulse(input bit [3:0] b);
        btn = b;
        tick();
        btn = 4'b0000;
    endtask

    task automatic settle(input int budget);
        int k;
        k = 0;
        while ((bus.busy !== 1'b0 || bus.pending !== 4'b0000) && k < budget) begin
            tick();
            k++;
        end
        chk("settle_done", (bus.busy === 1'b0 && bus.pending === 4'b0000) ? 1 : 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bus.call_btn = 4'b0000;
        bus.current_floor = 2'd0;
`ifdef SCHED_DOOR_HOLD_EN
        bus.door_hold = 1'b0;
`endif
        btn = 4'b0000; hold_v = 1'b0; rst_v = 1'b0; armed = 1'b0;
        plant = 0; cyc = 0; prev_door = 1'b0;
        m_pend = 4'b0000; m_dir = 1'b1; m_dwell = 0; m_step = 1'b0; m_arr = 1'b0;
        clear_stats();

        // reset values and a trip from floor 0 to floor 3
        do_reset();
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_stop_go", int'(bus.stop_go), 1);
        chk("rst_up_down", int'(bus.up_down), 1);
        chk("rst_door",    int'(bus.door_open), 0);
        chk("rst_busy",    int'(bus.busy), 0);
        pulse(4'b1000);
        chk("s1_latch", int'(bus.pending), 8);
        settle(200);
        chk("s1_steps", n_steps, 3);
        chk("s1_up_steps", n_up, 3);
        chk("s1_floor", int'(bus.current_floor), 3);
        chk("s1_door_cycles", n_door, DC);
        chk("s1_door_floor", (df.size() == 1) ? df[0] : -1, 3);

        // car idle at floor 2, call for floor 2
        pulse(4'b0100);
        settle(200);
        chk("s2_at_floor2", int'(bus.current_floor), 2);
        clear_stats();
        t0 = cyc;
        pulse(4'b0100);
        settle(200);
        chk("s2_door_latency", rise_cyc - t0, 2);
        chk("s2_no_steps", n_steps, 0);
        chk("s2_pending", int'(bus.pending), 0);

        // car at floor 1 heading up, calls for 3 and 0 together
        do_reset();
        pulse(4'b0010);
        settle(200);
        chk("s3_floor1", int'(bus.current_floor), 1);
        chk("s3_dir_up", int'(bus.up_down), 1);
        clear_stats();
        pulse(4'b1001);
        settle(300);
        chk("s3_stops", df.size(), 2);
        chk("s3_first", (df.size() > 0) ? df[0] : -1, 3);
        chk("s3_second", (df.size() > 1) ? df[1] : -1, 0);
        chk("s3_up", n_up, 2);
        chk("s3_down", n_down, 3);
        chk("s3_dir_down", int'(bus.up_down), 0);

        // intermediate call raised while passing floor 1 on the way to 3
        do_reset();
        clear_stats();
        pulse(4'b1000);
        for (int k = 0; k < 20 && bus.current_floor != 2'd1; k++) tick();
        chk("s4_reached1", int'(bus.current_floor), 1);
        pulse(4'b0100);
        settle(300);
        chk("s4_stops", df.size(), 2);
        chk("s4_first", (df.size() > 0) ? df[0] : -1, 2);
        chk("s4_second", (df.size() > 1) ? df[1] : -1, 3);

        // reset in the middle of a step toward floor 3
        do_reset();
        pulse(4'b1010);
        for (int k = 0; k < 20 && bus.stop_go !== 1'b0; k++) tick();
        chk("s5_stepping", int'(bus.stop_go), 0);
        chk("s5_pending_pre", int'(bus.pending), 10);
        rst_v = 1'b1;
        tick();
        rst_v = 1'b0;
        chk("s5_pending", int'(bus.pending), 0);
        chk("s5_stop_go", int'(bus.stop_go), 1);
        chk("s5_door", int'(bus.door_open), 0);
        chk("s5_busy", int'(bus.busy), 0);

`ifdef SCHED_DOOR_HOLD_EN
        // door held open for 10 cycles after it opens
        do_reset();
        clear_stats();
        pulse(4'b0001);
        for (int k = 0; k < 10 && bus.door_open !== 1'b1; k++) tick();
        chk("s6_door_up", int'(bus.door_open), 1);
        hold_v = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        hold_v = 1'b0;
        settle(100);
        chk("s6_door_cycles", n_door, 10 + DC);
        chk("s6_idle", int'(bus.busy), 0);
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            btn = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
`ifdef SCHED_DOOR_HOLD_EN
            hold_v = ($urandom_range(0, 7) == 0);
`endif
            rst_v = ($urandom_range(0, 599) == 0);
            tick();
        end
        btn = 4'b0000; hold_v = 1'b0; rst_v = 1'b0;
        settle(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request scheduler for the 4-floor car-position state machine. Latches floor call buttons, picks a travel direction with a SCAN (collective) policy, and drives that machine's `stop_go`/`up_down` inputs one floor step at a time. It reads the machine's `output_floor` back as `current_floor`, stops at every pending floor it reaches, and holds the door open for a fixed dwell. It sits between the button/panel logic and the floor state machine, on the same clock and reset.

## Interface
- `DOOR_CYCLES`, default 8: door-open dwell in clock cycles; legal range 1..255; 8-bit counter.

- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `call_btn`  in  4  per-floor call request; bit i = floor i; level or pulse; sampled every cycle.
- `current_floor`  in  2  car position fed back from the floor state machine (00 = floor 0 .. 11 = floor 3).
- `door_hold`  in  1  extends door dwell; present only with `SCHED_DOOR_HOLD_EN`.
- `stop_go`  out  1  to floor machine: 0 = step one floor this cycle, 1 = hold.
- `up_down`  out  1  to floor machine: 1 = up, 0 = down; equals the internal direction register.
- `door_open`  out  1  high while in DOOR.
- `pending`  out  4  latched outstanding requests.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Request latch: `pending <= (pending | call_btn) & ~clr`.
  - `clr` is the one-hot of `current_floor` on the cycle DOOR is entered.
  - `call_btn[current_floor]` is masked (not latched) while in DOOR.
- "Ahead" means any pending bit strictly above `current_floor` when `dir`=up, or strictly below when `dir`=down.
- FSM states: IDLE, STEP, CHECK, DOOR.
- IDLE (`stop_go`=1):
  - If `pending[current_floor]`: go to DOOR.
  - Else if `pending` is nonzero: update `dir` by SCAN, then go to STEP.
    - `dir`=up: stay up if any request is above, else switch down.
    - `dir`=down: stay down if any request is below, else switch up.
  - Else: stay in IDLE.
- STEP: `stop_go`=0 and `up_down`=`dir` for exactly one cycle, then go to CHECK.
- CHECK (`stop_go`=1; `current_floor` now shows the new floor):
  - If `pending[current_floor]`: go to DOOR.
  - Else if any request is ahead: go to STEP.
  - Else: go to IDLE.
- DOOR:
  - On entry: clear `pending[current_floor]` and load the counter with `DOOR_CYCLES`-1.
  - `door_open`=1 while in DOOR.
  - Decrement each cycle; at 0 go to IDLE.
- `stop_go` is never 0 while `door_open`=1.
- `dir` is never toggled in STEP, CHECK or DOOR.
- Boundary: the block never issues a STEP that is up at floor 3 or down at floor 0. The SCAN rule guarantees this, because no request can lie beyond either end.

## Timing
- Reset values: state IDLE, `stop_go`=1, `up_down`=1 (`dir`=up), `door_open`=0, `pending`=0000, `busy`=0, counter 0.
- Call to latch: `pending` bit is visible the cycle after `call_btn` is asserted.
- Travel: n floors take 2n cycles (STEP + CHECK per floor).
  - From the first STEP to DOOR entry is 2n cycles.
- Dwell: `door_open` is high for exactly `DOOR_CYCLES` consecutive cycles.
  - The next cycle is IDLE, which re-evaluates immediately.
- Call at the current floor while in IDLE: latched at cycle t+1, DOOR at t+2. No STEP is issued.
- Call for a floor arriving in the same cycle as the CHECK at that floor: not yet in `pending`, so the car passes it; the request is served later under SCAN.
- `RST` mid-operation: all state returns to reset values on the next edge.
  - Pending requests are discarded.
  - The floor state machine shares `RST`, so position returns to floor 0 coherently.

## Configuration
- `SCHED_DOOR_HOLD_EN` defined:
  - `door_hold` port exists.
  - While `door_hold`=1 in DOOR, the counter reloads `DOOR_CYCLES`-1 every cycle.
  - DOOR exits `DOOR_CYCLES` cycles after `door_hold` falls.
- `SCHED_DOOR_HOLD_EN` undefined: no `door_hold` port; dwell is fixed at `DOOR_CYCLES`.

## Test plan
- Reset, car at 0, pulse `call_btn`=1000:
  - `pending`=1000 next cycle.
  - Three single-cycle `stop_go`=0 pulses with `up_down`=1.
  - `current_floor`=3, then `door_open` high for 8 cycles.
  - `pending`=0000, `busy`=0.
- Car idle at 2, pulse `call_btn`=0100:
  - `door_open` rises 2 cycles later.
  - No `stop_go`=0 pulse.
  - `pending` returns to 0000.
- Car at 1 with `dir`=up, calls 1000 and 0001 latched together:
  - Serves floor 3 first.
  - Then `up_down`=0 and three down steps to floor 0.
- Car stepping 0→3; raise `call_btn`=0100 while `current_floor`=1:
  - Car stops at 2 (door dwell), then continues to 3.
- Assert `RST` during STEP toward floor 3 with `pending`=1010:
  - Next cycle `pending`=0000, `stop_go`=1, `door_open`=0, IDLE.
- With `SCHED_DOOR_HOLD_EN` and `DOOR_CYCLES`=4: hold `door_hold`=1 for 10 cycles after door opens.
  - `door_open` stays high through the hold plus 4 cycles.
  - Then returns to IDLE.
